// File: rtl/muldiv_sequencer_pkg.sv
// Shared op codes, FSM states and decode helpers for the HI/LO multiply/divide sequencer.
package muldiv_sequencer_pkg;

    localparam logic [2:0] md_mult  = 3'd0;
    localparam logic [2:0] md_multu = 3'd1;
    localparam logic [2:0] md_div   = 3'd2;
    localparam logic [2:0] md_divu  = 3'd3;
    localparam logic [2:0] md_mthi  = 3'd4;
    localparam logic [2:0] md_mtlo  = 3'd5;

    typedef enum logic [1:0] {
        md_idle  = 2'd0,
        md_iter  = 2'd1,
        md_fixup = 2'd2
    } md_state_t;

    // True for the ops that run the 34-cycle iterative sequence.
    function automatic logic is_iterative(input logic [2:0] op);
        return (op == md_mult) || (op == md_multu) || (op == md_div) || (op == md_divu);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == md_mult) || (op == md_div);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == md_div) || (op == md_divu);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide,
// both on the same adder with two guard bits.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH+1:0] lhs;
    logic [WIDTH+1:0] rhs;
    logic [WIDTH+1:0] sum;

    always_comb begin
        if (mode_div) begin
            // Partial remainder shifted left with the next dividend bit; subtract the divisor.
            lhs = {1'b0, acc, q[WIDTH-1]};
            rhs = ~{2'b00, operand};
            sum = lhs + rhs + {{(WIDTH+1){1'b0}}, 1'b1};
            if (!sum[WIDTH+1]) begin
                acc_next = sum[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = lhs[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            lhs      = {2'b00, acc};
            rhs      = q[0] ? {2'b00, operand} : '0;
            sum      = lhs + rhs;
            acc_next = sum[WIDTH:1];
            q_next   = {sum[0], q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: latches magnitudes, runs WIDTH steps,
// then applies sign fixup and writes HI/LO in a final cycle.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    md_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic             div_reg;
    logic             sign_a_reg;
    logic             sign_b_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic             sa_in;
    logic             sb_in;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_div (div_reg),
        .acc      (acc_reg),
        .q        (q_reg),
        .operand  (opnd_reg),
        .acc_next (acc_next),
        .q_next   (q_next)
    );

    // Magnitudes of the incoming operands; INT_MIN maps to its unsigned value.
    always_comb begin
        sa_in = is_signed_op(op) && A[WIDTH-1];
        sb_in = is_signed_op(op) && B[WIDTH-1];
        mag_a = sa_in ? (~A + 1'b1) : A;
        mag_b = sb_in ? (~B + 1'b1) : B;
    end

    // Sign fixup; a zero divisor leaves the remainder equal to the original A.
    always_comb begin
        prod     = {acc_reg, q_reg};
        prod_neg = ~prod + 1'b1;
        if (div_reg) begin
            lo_next = (sign_a_reg ^ sign_b_reg) ? (~q_reg + 1'b1) : q_reg;
            hi_next = sign_a_reg ? (~acc_reg + 1'b1) : acc_reg;
            if (opnd_reg == '0) begin
                lo_next = '1;
            end
        end else begin
            {hi_next, lo_next} = (sign_a_reg ^ sign_b_reg) ? prod_neg : prod;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= md_idle;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            q_reg      <= '0;
            opnd_reg   <= '0;
            div_reg    <= 1'b0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (flush) begin
                state_reg <= md_idle;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    md_idle: begin
                        if (start && is_iterative(op)) begin
                            state_reg  <= md_iter;
                            busy_reg   <= 1'b1;
                            cnt_reg    <= '1;
                            acc_reg    <= '0;
                            div_reg    <= is_div_op(op);
                            sign_a_reg <= sa_in;
                            sign_b_reg <= sb_in;
                            q_reg      <= is_div_op(op) ? mag_a : mag_b;
                            opnd_reg   <= is_div_op(op) ? mag_b : mag_a;
                        end else if (start && op == md_mthi) begin
                            hi_reg <= A;
                        end else if (start && op == md_mtlo) begin
                            lo_reg <= A;
                        end
                    end
                    md_iter: begin
                        acc_reg <= acc_next;
                        q_reg   <= q_next;
                        if (cnt_reg == '0) begin
                            state_reg <= md_fixup;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                    md_fixup: begin
                        hi_reg    <= hi_next;
                        lo_reg    <= lo_next;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= md_idle;
                    end
                    default: begin
                        state_reg <= md_idle;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
